// File: rtl/noc_packetizer.sv
// Local-side NoC packetizer: turns (dest, len) requests plus payload words into a header flit
// and body flits behind a registered output stage. Optional header sequence number: NOC_PKT_SEQ_EN.
module noc_packetizer #(
    parameter int unsigned X_ID    = 0,
    parameter int unsigned Y_ID    = 0,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned LEN_W   = 8
) (
    input  logic               noc_clk,
    input  logic               noc_rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_dest_x,
    input  logic [COORD_W-1:0] req_dest_y,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [DATA_W-1:0]  data_word,
    output logic               sender_valid,
    input  logic               sender_ready,
    output logic [DATA_W-1:0]  sender_flit,
    output logic               sender_is_header,
    output logic               sender_is_tail,
    output logic [15:0]        tx_pkt_cnt
);

    typedef enum logic [0:0] {
        StIdle,
        StBody
    } state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] flit_q, flit_d;
    logic              is_header_q, is_header_d;
    logic              is_tail_q, is_tail_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;

    logic              out_free;
    logic              req_hs;
    logic              data_hs;
    logic [DATA_W-1:0] header;

`ifdef NOC_PKT_SEQ_EN
    logic [7:0]        seq_q, seq_d;
`endif

    // The output register can take a new flit when empty or being drained this cycle.
    assign out_free = !valid_q || sender_ready;
    assign req_hs   = req_valid && req_ready;
    assign data_hs  = data_valid && data_ready;

    always_comb begin
        header        = '0;
        header[3:0]   = 4'(req_dest_x);
        header[7:4]   = 4'(req_dest_y);
        header[11:8]  = 4'(X_ID);
        header[15:12] = 4'(Y_ID);
        header[23:16] = 8'(req_len);
`ifdef NOC_PKT_SEQ_EN
        header[31:24] = seq_q;
`endif
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        flit_d      = flit_q;
        is_header_d = is_header_q;
        is_tail_d   = is_tail_q;
        remaining_d = remaining_q;
        pkt_cnt_d   = pkt_cnt_q;
        req_ready   = 1'b0;
        data_ready  = 1'b0;

        if (valid_q && sender_ready) begin
            valid_d = 1'b0;
            if (is_tail_q) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                req_ready = noc_rst_n && out_free;
                if (req_hs) begin
                    valid_d     = 1'b1;
                    flit_d      = header;
                    is_header_d = 1'b1;
                    is_tail_d   = (req_len == '0);
                    remaining_d = req_len;
                    if (req_len != '0) begin
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                data_ready = noc_rst_n && out_free;
                if (data_hs) begin
                    valid_d     = 1'b1;
                    flit_d      = data_word;
                    is_header_d = 1'b0;
                    is_tail_d   = (remaining_q == LEN_W'(1));
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef NOC_PKT_SEQ_EN
    always_comb begin
        seq_d = seq_q;
        if (req_hs) begin
            seq_d = seq_q + 8'd1;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            seq_q <= 8'd0;
        end else begin
            seq_q <= seq_d;
        end
    end
`endif

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q     <= StIdle;
            valid_q     <= 1'b0;
            flit_q      <= '0;
            is_header_q <= 1'b0;
            is_tail_q   <= 1'b0;
            remaining_q <= '0;
            pkt_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            flit_q      <= flit_d;
            is_header_q <= is_header_d;
            is_tail_q   <= is_tail_d;
            remaining_q <= remaining_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign sender_valid     = valid_q;
    assign sender_flit      = flit_q;
    assign sender_is_header = is_header_q;
    assign sender_is_tail   = is_tail_q;
    assign tx_pkt_cnt       = pkt_cnt_q;

`ifndef SYNTHESIS
    // A stalled flit must not change until the router takes it.
    assert property (@(posedge noc_clk) disable iff (!noc_rst_n)
        (sender_valid && !sender_ready) |=> (sender_valid && $stable(sender_flit) &&
                                             $stable(sender_is_header) && $stable(sender_is_tail)));

    assert property (@(posedge noc_clk) disable iff (!noc_rst_n) !(req_ready && data_ready));
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// Self-checking bench for noc_packetizer: table-driven headers, directed corner sequences and
// randomized traffic against an in-order expected-flit-stream model.
module tb_noc_packetizer;

    localparam int unsigned XI = 5;
    localparam int unsigned YI = 9;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_dest_x = '0;
    logic [3:0]  req_dest_y = '0;
    logic [7:0]  req_len = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [31:0] data_word = '0;
    logic        sender_valid;
    logic        sender_ready = 1'b1;
    logic [31:0] sender_flit;
    logic        sender_is_header;
    logic        sender_is_tail;
    logic [15:0] tx_pkt_cnt;

    noc_packetizer #(
        .X_ID   (XI),
        .Y_ID   (YI),
        .DATA_W (32),
        .COORD_W(4),
        .LEN_W  (8)
    ) dut (
        .noc_clk         (noc_clk),
        .noc_rst_n       (noc_rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dest_x      (req_dest_x),
        .req_dest_y      (req_dest_y),
        .req_len         (req_len),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .data_word       (data_word),
        .sender_valid    (sender_valid),
        .sender_ready    (sender_ready),
        .sender_flit     (sender_flit),
        .sender_is_header(sender_is_header),
        .sender_is_tail  (sender_is_tail),
        .tx_pkt_cnt      (tx_pkt_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic [31:0] flit;
        logic        hdr;
        logic        tail;
    } exp_t;

    typedef struct {
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [7:0]  len;
        logic [31:0] hdr;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    logic [31:0] pw[$];
    int          out_log[$];
    logic [15:0] exp_cnt = 16'd0;
    bit          rand_bp = 1'b0;
    logic [34:0] snap;
`ifdef NOC_PKT_SEQ_EN
    logic [7:0]  exp_seq = 8'd0;
`endif

    always @(posedge noc_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for handshake (cycle %0d)", name, cyc);
    endtask

    // Header built from the field layout: dest_x, dest_y, X_ID, Y_ID, len from bit 0 upward.
    function automatic logic [31:0] hdr_model(input logic [3:0] dx, input logic [3:0] dy,
                                              input logic [7:0] len);
        return {8'h00, len, 4'(YI), 4'(XI), dy, dx};
    endfunction

    task automatic push_pkt(input logic [31:0] hdr, input int len);
        exp_t e;
        e.flit = hdr;
`ifdef NOC_PKT_SEQ_EN
        e.flit[31:24] = exp_seq;
        exp_seq = exp_seq + 8'd1;
`endif
        e.hdr  = 1'b1;
        e.tail = (len == 0);
        exp_q.push_back(e);
        for (int i = 0; i < len; i++) begin
            e.flit = pw[i];
            e.hdr  = 1'b0;
            e.tail = (i == len - 1);
            exp_q.push_back(e);
        end
    endtask

    // Present a request (optionally with a stray payload word) until accepted.
    task automatic do_req(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len,
                          input logic [31:0] hdr, input bit early);
        int n = 0;
        bit done = 1'b0;
        req_valid  = 1'b1;
        req_dest_x = dx;
        req_dest_y = dy;
        req_len    = len;
        data_valid = early;
        data_word  = (len != 0) ? pw[0] : $urandom;
        while (!done) begin
            @(negedge noc_clk);
            if (early) check("idle_data_ignored", 64'(data_ready), 64'd0);
            if (req_ready) begin
                push_pkt(hdr, int'(len));
                done = 1'b1;
            end else if (++n > 200) begin
                timeout("req_accept");
                done = 1'b1;
            end
            @(posedge noc_clk);
            #1;
        end
        req_valid  = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic do_word(input logic [31:0] w, input int gap);
        int n = 0;
        bit done = 1'b0;
        repeat (gap) begin
            @(posedge noc_clk);
            #1;
        end
        data_valid = 1'b1;
        data_word  = w;
        while (!done) begin
            @(negedge noc_clk);
            if (data_ready) begin
                done = 1'b1;
            end else if (++n > 200) begin
                timeout("data_accept");
                done = 1'b1;
            end
            @(posedge noc_clk);
            #1;
        end
        data_valid = 1'b0;
    endtask

    task automatic do_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len,
                          input logic [31:0] hdr, input bit early, input int max_gap);
        do_req(dx, dy, len, hdr, early);
        for (int i = 0; i < int'(len); i++) do_word(pw[i], $urandom_range(0, max_gap));
    endtask

    task automatic fill_words(input int len);
        pw.delete();
        for (int i = 0; i < len; i++) pw.push_back($urandom | 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        sender_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge noc_clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: in-order flit stream, load latency, hold under backpressure, packet count.
    initial begin
        bit          prev_in_hs = 1'b0;
        bit          prev_hdr = 1'b0;
        bit          prev_stall = 1'b0;
        logic [34:0] prev_snap = '0;
        exp_t        e;
        forever begin
            @(negedge noc_clk);
            if (!noc_rst_n) begin
                prev_in_hs = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_in_hs) begin
                    check("latency_valid", 64'(sender_valid), 64'd1);
                    check("latency_kind", 64'(sender_is_header), 64'(prev_hdr));
                end
                if (prev_stall) begin
                    check("hold_stable",
                          64'({sender_valid, sender_is_header, sender_is_tail, sender_flit}),
                          64'(prev_snap));
                end
                if (sender_valid && sender_ready) begin
                    out_log.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        timeout("unexpected_flit");
                    end else begin
                        e = exp_q.pop_front();
                        check("flit", 64'(sender_flit), 64'(e.flit));
                        check("is_header", 64'(sender_is_header), 64'(e.hdr));
                        check("is_tail", 64'(sender_is_tail), 64'(e.tail));
                        check("tx_pkt_cnt", 64'(tx_pkt_cnt), 64'(exp_cnt));
                        if (e.tail) exp_cnt = exp_cnt + 16'd1;
                    end
                end
                prev_in_hs = (req_valid && req_ready) || (data_valid && data_ready);
                prev_hdr   = req_valid && req_ready;
                prev_stall = sender_valid && !sender_ready;
                prev_snap  = {sender_valid, sender_is_header, sender_is_tail, sender_flit};
            end
        end
    end

    initial begin
        forever begin
            @(posedge noc_clk);
            #1;
            if (rand_bp) sender_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[6];
        logic [15:0] cnt0;

        tbl[0] = '{dx: 4'd1,  dy: 4'd1,  len: 8'd0, hdr: 32'h0000_9511};
        tbl[1] = '{dx: 4'd15, dy: 4'd0,  len: 8'd0, hdr: 32'h0000_950F};
        tbl[2] = '{dx: 4'd3,  dy: 4'd12, len: 8'd2, hdr: 32'h0002_95C3};
        tbl[3] = '{dx: 4'd10, dy: 4'd5,  len: 8'd1, hdr: 32'h0001_955A};
        tbl[4] = '{dx: 4'd7,  dy: 4'd7,  len: 8'd3, hdr: 32'h0003_9577};
        tbl[5] = '{dx: 4'd0,  dy: 4'd15, len: 8'd5, hdr: 32'h0005_95F0};

        // Reset state, with requests and data offered during reset.
        req_valid  = 1'b1;
        data_valid = 1'b1;
        #12;
        check("rst_sender_valid", 64'(sender_valid), 64'd0);
        check("rst_flit", 64'({sender_flit, sender_is_header, sender_is_tail}), 64'd0);
        check("rst_cnt", 64'(tx_pkt_cnt), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_data_ready", 64'(data_ready), 64'd0);
        req_valid  = 1'b0;
        data_valid = 1'b0;
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        @(negedge noc_clk);
        check("idle_req_ready", 64'(req_ready), 64'd1);
        check("idle_data_ready", 64'(data_ready), 64'd0);
        @(posedge noc_clk);
        #1;

        // Table-driven headers with short payloads.
        for (int i = 0; i < 6; i++) begin
            fill_words(int'(tbl[i].len));
            do_req(tbl[i].dx, tbl[i].dy, tbl[i].len, tbl[i].hdr, 1'b1);
            for (int k = 0; k < int'(tbl[i].len); k++) do_word(pw[k], k % 2);
        end
        drain();
        check("table_cnt", 64'(tx_pkt_cnt), 64'd6);

        // Full rate: header, A, B, C, then the next header with no bubble.
        out_log.delete();
        pw.delete();
        pw.push_back(32'hA);
        pw.push_back(32'hB);
        pw.push_back(32'hC);
        do_req(4'd1, 4'd2, 8'd3, hdr_model(4'd1, 4'd2, 8'd3), 1'b1);
        for (int i = 0; i < 3; i++) do_word(pw[i], 0);
        pw.delete();
        do_req(4'd6, 4'd6, 8'd0, hdr_model(4'd6, 4'd6, 8'd0), 1'b0);
        drain();
        check("rate_count", 64'(out_log.size()), 64'd5);
        for (int i = 1; i < out_log.size(); i++) begin
            check("rate_gap", 64'(out_log[i] - out_log[i-1]), 64'd1);
        end

        // Backpressure for 5 cycles mid-body.
        fill_words(4);
        fork
            do_pkt(4'd5, 4'd10, 8'd4, hdr_model(4'd5, 4'd10, 8'd4), 1'b0, 0);
            begin
                repeat (3) @(posedge noc_clk);
                #1;
                sender_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge noc_clk);
                    check("bp_valid", 64'(sender_valid), 64'd1);
                    check("bp_data_ready", 64'(data_ready), 64'd0);
                    if (i == 0) begin
                        snap = {sender_valid, sender_is_header, sender_is_tail, sender_flit};
                    end else begin
                        check("bp_hold",
                              64'({sender_valid, sender_is_header, sender_is_tail, sender_flit}),
                              64'(snap));
                    end
                end
                @(posedge noc_clk);
                #1;
                sender_ready = 1'b1;
            end
        join
        drain();

        // Payload starvation mid-packet; a request offered in BODY must be ignored.
        fill_words(4);
        do_req(4'd9, 4'd3, 8'd4, hdr_model(4'd9, 4'd3, 8'd4), 1'b0);
        do_word(pw[0], 0);
        do_word(pw[1], 0);
        req_valid  = 1'b1;
        req_dest_x = 4'd2;
        req_len    = 8'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge noc_clk);
            check("starve_data_ready", 64'(data_ready), 64'd1);
            check("starve_req_ready", 64'(req_ready), 64'd0);
            if (i > 0) check("starve_valid", 64'(sender_valid), 64'd0);
        end
        @(posedge noc_clk);
        #1;
        req_valid = 1'b0;
        do_word(pw[2], 0);
        do_word(pw[3], 0);
        drain();

        // Asynchronous reset with the first of 4 body flits in the output register.
        fill_words(4);
        do_req(4'd2, 4'd3, 8'd4, hdr_model(4'd2, 4'd3, 8'd4), 1'b0);
        do_word(pw[0], 0);
        #1;
        noc_rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(sender_valid), 64'd0);
        check("arst_flit", 64'({sender_flit, sender_is_header, sender_is_tail}), 64'd0);
        check("arst_cnt", 64'(tx_pkt_cnt), 64'd0);
        check("arst_readies", 64'({req_ready, data_ready}), 64'd0);
        exp_q.delete();
        exp_cnt = 16'd0;
`ifdef NOC_PKT_SEQ_EN
        exp_seq = 8'd0;
`endif
        repeat (2) @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        fill_words(2);
        do_pkt(4'd4, 4'd1, 8'd2, hdr_model(4'd4, 4'd1, 8'd2), 1'b0, 0);
        drain();
        check("post_rst_cnt", 64'(tx_pkt_cnt), 64'd1);

        // 257 back-to-back header-only packets (sequence wrap when enabled).
        cnt0 = tx_pkt_cnt;
        pw.delete();
        for (int i = 0; i < 257; i++) begin
            do_req(4'(i), 4'(i >> 4), 8'd0, hdr_model(4'(i), 4'(i >> 4), 8'd0), 1'b0);
        end
        drain();
        check("burst_cnt", 64'(tx_pkt_cnt), 64'(cnt0 + 16'd257));

        // Randomized traffic with random backpressure and payload gaps.
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] dx;
            logic [3:0] dy;
            logic [7:0] len;
            dx  = 4'($urandom);
            dy  = 4'($urandom);
            len = 8'($urandom_range(0, 6));
            fill_words(int'(len));
            do_pkt(dx, dy, len, hdr_model(dx, dy, len), 1'($urandom_range(0, 1)), 2);
        end
        rand_bp = 1'b0;
        drain();
        check("final_cnt", 64'(tx_pkt_cnt), 64'(exp_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
